qrs_span_reader: RTL

- Consumer of the refined QRS boundaries (q_begin_ref, s_end_ref) produced at original-sample resolution by the QRS refinement stage.
- On a start strobe it latches the boundaries, validates the span and walks the original-resolution ECG sample RAM from Q-onset to S-offset, one address per cycle.
- Produces the QRS duration plus maximum (R) and minimum (S) amplitude with their sample indices, for the downstream feature/classification stage.

---
 rtl/qrs_span_reader.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/qrs_span_reader.sv
// qrs_span_reader
//   Takes the refined QRS boundaries (Q-onset / S-offset, original-sample
//   resolution), validates the span, walks the ECG sample RAM from Q to S
//   one address per cycle, and reports the QRS duration plus the maximum (R)
//   and minimum (S) amplitudes with their sample indices.
//
// Ports:
//   clk          system clock, rising edge
//   nReset       synchronous reset, active HIGH despite the name
//   start        one-cycle request, accepted only in IDLE
//   q_begin_ref  signed Q-onset index (negative clamps to 0)
//   s_end_ref    signed S-offset index
//   rd_en        sample RAM read enable
//   rd_addr      sample RAM read address
//   rd_data      signed RAM data, valid one cycle after rd_en
//   busy         high whenever the block is not IDLE
//   done         one-cycle completion pulse
//   err          span-invalid flag, valid with done, held until next done
//   qrs_dur      span length in samples (0 on error)
//   r_amp/r_idx  maximum sample and its address
//   s_amp/s_idx  minimum sample and its address
module qrs_span_reader #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MAX_SPAN = 512
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              start,
  input  logic [15:0]       q_begin_ref,
  input  logic [15:0]       s_end_ref,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       qrs_dur,
  output logic [DATA_W-1:0] r_amp,
  output logic [15:0]       r_idx,
  output logic [DATA_W-1:0] s_amp,
  output logic [15:0]       s_idx
);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    READ,
    DRAIN,
    DONE
  } state_t;

  localparam logic signed [16:0] MAX_SPAN_S = 17'(MAX_SPAN);
  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MOST_POS = {1'b0, {(DATA_W-1){1'b1}}};

  state_t              state_q, state_d;
  logic [15:0]         q_lat_q, q_lat_d;
  logic [15:0]         s_lat_q, s_lat_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   s_addr_q, s_addr_d;
  logic [15:0]         span_q, span_d;
  logic [DATA_W-1:0]   max_q, max_d;
  logic [15:0]         max_idx_q, max_idx_d;
  logic [DATA_W-1:0]   min_q, min_d;
  logic [15:0]         min_idx_q, min_idx_d;
  logic                cmp_vld_q, cmp_vld_d;
  logic [ADDR_W-1:0]   cmp_idx_q, cmp_idx_d;
  logic                err_q, err_d;
  logic [15:0]         dur_q, dur_d;
  logic [DATA_W-1:0]   r_amp_q, r_amp_d;
  logic [15:0]         r_idx_q, r_idx_d;
  logic [DATA_W-1:0]   s_amp_q, s_amp_d;
  logic [15:0]         s_idx_q, s_idx_d;

  logic [15:0]         q_clamp;
  logic signed [16:0]  q_ext;
  logic signed [16:0]  s_ext;
  logic signed [16:0]  span_ext;
  logic                span_bad;

  // Span arithmetic is done in 17-bit signed so s - q + 1 can never wrap,
  // whatever the 16-bit signed boundary values are.
  always_comb begin
    q_clamp  = q_lat_q[15] ? 16'h0000 : q_lat_q;
    q_ext    = signed'({1'b0, q_clamp});
    s_ext    = signed'({s_lat_q[15], s_lat_q});
    span_ext = s_ext - q_ext + 17'sd1;
    span_bad = (s_ext < q_ext) || (span_ext > MAX_SPAN_S);
  end

  always_comb begin
    state_d   = state_q;
    q_lat_d   = q_lat_q;
    s_lat_d   = s_lat_q;
    addr_d    = addr_q;
    s_addr_d  = s_addr_q;
    span_d    = span_q;
    max_d     = max_q;
    max_idx_d = max_idx_q;
    min_d     = min_q;
    min_idx_d = min_idx_q;
    err_d     = err_q;
    dur_d     = dur_q;
    r_amp_d   = r_amp_q;
    r_idx_d   = r_idx_q;
    s_amp_d   = s_amp_q;
    s_idx_d   = s_idx_q;
    cmp_vld_d = (state_q == READ);
    cmp_idx_d = addr_q;

    // Strict compares keep the first (lowest) index on ties.
    if (cmp_vld_q) begin
      if ($signed(rd_data) > $signed(max_q)) begin
        max_d     = rd_data;
        max_idx_d = 16'(cmp_idx_q);
      end
      if ($signed(rd_data) < $signed(min_q)) begin
        min_d     = rd_data;
        min_idx_d = 16'(cmp_idx_q);
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          q_lat_d = q_begin_ref;
          s_lat_d = s_end_ref;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (span_bad) begin
          err_d   = 1'b1;
          dur_d   = 16'h0000;
          r_amp_d = '0;
          r_idx_d = 16'h0000;
          s_amp_d = '0;
          s_idx_d = 16'h0000;
          state_d = DONE;
        end else begin
          max_d    = MOST_NEG;
          min_d    = MOST_POS;
          addr_d   = ADDR_W'(q_clamp);
          s_addr_d = ADDR_W'(s_lat_q);
          span_d   = span_ext[15:0];
          state_d  = READ;
        end
      end
      READ: begin
        if (addr_q == s_addr_q) begin
          state_d = DRAIN;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      DRAIN: begin
        // Results are taken from the _d values so the last sample, compared
        // in this very cycle, is included.
        err_d   = 1'b0;
        dur_d   = span_q;
        r_amp_d = max_d;
        r_idx_d = max_idx_d;
        s_amp_d = min_d;
        s_idx_d = min_idx_d;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (nReset) begin
      state_q   <= IDLE;
      q_lat_q   <= '0;
      s_lat_q   <= '0;
      addr_q    <= '0;
      s_addr_q  <= '0;
      span_q    <= '0;
      max_q     <= '0;
      max_idx_q <= '0;
      min_q     <= '0;
      min_idx_q <= '0;
      cmp_vld_q <= 1'b0;
      cmp_idx_q <= '0;
      err_q     <= 1'b0;
      dur_q     <= '0;
      r_amp_q   <= '0;
      r_idx_q   <= '0;
      s_amp_q   <= '0;
      s_idx_q   <= '0;
    end else begin
      state_q   <= state_d;
      q_lat_q   <= q_lat_d;
      s_lat_q   <= s_lat_d;
      addr_q    <= addr_d;
      s_addr_q  <= s_addr_d;
      span_q    <= span_d;
      max_q     <= max_d;
      max_idx_q <= max_idx_d;
      min_q     <= min_d;
      min_idx_q <= min_idx_d;
      cmp_vld_q <= cmp_vld_d;
      cmp_idx_q <= cmp_idx_d;
      err_q     <= err_d;
      dur_q     <= dur_d;
      r_amp_q   <= r_amp_d;
      r_idx_q   <= r_idx_d;
      s_amp_q   <= s_amp_d;
      s_idx_q   <= s_idx_d;
    end
  end

  assign rd_en   = (state_q == READ);
  assign rd_addr = addr_q;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign err     = err_q;
  assign qrs_dur = dur_q;
  assign r_amp   = r_amp_q;
  assign r_idx   = r_idx_q;
  assign s_amp   = s_amp_q;
  assign s_idx   = s_idx_q;

endmodule
